bvh_traversal_sequencer: RTL and testbench

- Per-ray BVH traversal controller. Walks the 128-bit packed node format (bbox min/max plus a 32-bit union field) from a root address.
- Issues node fetches to the node memory and consumes each returned node together with an external ray/box hit bit.
- Keeps a small stack of deferred far children and emits leaf primitive ranges to the intersection unit.
- Sits between the ray dispatcher and the node cache / box tester / triangle tester in the RT core.

---
 rtl/bvh_traversal_sequencer.sv | 137 +++++++++++++
 tb/tb_bvh_traversal_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bvh_traversal_sequencer.sv
// bvh_traversal_sequencer: per-ray BVH walk with a deferred far-child stack.
// Define BVH_TRAV_STATS_EN to add saturating node/leaf statistics outputs.
module bvh_traversal_sequencer #(
    parameter int ADDR_W      = 24,
    parameter int STACK_DEPTH = 8,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ADDR_W-1:0] root_addr,
    input  logic [2:0]        ray_dir_neg,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              resp_valid,
    input  logic [127:0]      resp_word,
    input  logic              resp_hit,
    output logic              leaf_valid,
    input  logic              leaf_ready,
    output logic [19:0]       leaf_prim_index,
    output logic [11:0]       leaf_prim_count,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef BVH_TRAV_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_nodes,
    output logic [STAT_W-1:0] stat_leaves
`endif
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, POP} state_t;
    state_t state;
    logic [SP_W-1:0] sp;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [2:0] dir;
    logic [1:0] axis;
    logic [ADDR_W-1:0] child0, child1, near, far;
    logic [SP_W-1:0] sp_dec;
    logic full, push, is_leaf, empty_leaf;
    logic unused_bbox;
    assign unused_bbox = ^resp_word[127:32];
    // fetch_addr doubles as the current node address
    assign axis       = resp_word[30:29] == 2'd3 ? 2'd0 : resp_word[30:29];
    assign child0     = fetch_addr + ADDR_W'(resp_word[28:15]);
    assign child1     = fetch_addr + ADDR_W'(resp_word[14:0]);
    assign near       = dir[axis] ? child1 : child0;
    assign far        = dir[axis] ? child0 : child1;
    assign sp_dec     = sp - 1'b1;
    assign full       = sp == SP_W'(STACK_DEPTH);
    assign is_leaf    = resp_word[31];
    assign empty_leaf = is_leaf && resp_word[11:0] == 12'd0;
    assign push       = state == WAIT && resp_valid && resp_hit && !is_leaf && !full;
    always_ff @(posedge clk)
        if (push) stack[sp[SP_W-2:0]] <= far;
`ifdef BVH_TRAV_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stat_nodes  <= '0;
            stat_leaves <= '0;
        end else if (state == IDLE && start_valid) begin
            stat_nodes  <= '0;
            stat_leaves <= '0;
        end else begin
            if (state == WAIT && resp_valid) stat_nodes <= stat_nodes + STAT_W'(~&stat_nodes);
            if (state == EMIT && leaf_ready) stat_leaves <= stat_leaves + STAT_W'(~&stat_leaves);
        end
`else
    localparam int unused_stat_w = STAT_W;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state           <= IDLE;
            sp              <= '0;
            dir             <= '0;
            start_ready     <= 1'b1;
            fetch_valid     <= 1'b0;
            fetch_addr      <= '0;
            leaf_valid      <= 1'b0;
            leaf_prim_index <= '0;
            leaf_prim_count <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start_valid) begin
                    fetch_addr  <= root_addr;
                    dir         <= ray_dir_neg;
                    overflow    <= 1'b0;
                    sp          <= '0;
                    fetch_valid <= 1'b1;
                    start_ready <= 1'b0;
                    busy        <= 1'b1;
                    state       <= FETCH;
                end
                FETCH: if (fetch_ready) begin
                    fetch_valid <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: if (resp_valid) begin
                    if (!resp_hit || empty_leaf) state <= POP;
                    else if (is_leaf) begin
                        leaf_prim_index <= {1'b0, resp_word[30:12]};
                        leaf_prim_count <= resp_word[11:0];
                        leaf_valid      <= 1'b1;
                        state           <= EMIT;
                    end else begin
                        if (full) overflow <= 1'b1;
                        else sp <= sp + 1'b1;
                        fetch_addr  <= near;
                        fetch_valid <= 1'b1;
                        state       <= FETCH;
                    end
                end
                EMIT: if (leaf_ready) begin
                    leaf_valid <= 1'b0;
                    state      <= POP;
                end
                POP: if (sp == '0) begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    state       <= IDLE;
                end else begin
                    fetch_addr  <= stack[sp_dec[SP_W-2:0]];
                    sp          <= sp_dec;
                    fetch_valid <= 1'b1;
                    state       <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_bvh_traversal_sequencer.sv
// tb_bvh_traversal_sequencer: directed and random rays checked against a queue-based traversal model.
module tb_bvh_traversal_sequencer;
    localparam int AW = 24;
    localparam int SD = 8;
    logic clk = 0, rst = 1;
    logic start_valid = 0, start_ready;
    logic [AW-1:0] root_addr = '0;
    logic [2:0] ray_dir_neg = '0;
    logic fetch_valid, fetch_ready = 0;
    logic [AW-1:0] fetch_addr;
    logic resp_valid = 0, resp_hit = 0;
    logic [127:0] resp_word = '0;
    logic leaf_valid, leaf_ready = 0;
    logic [19:0] leaf_prim_index;
    logic [11:0] leaf_prim_count;
    logic busy, done, overflow;
    always #5 clk = ~clk;
    bvh_traversal_sequencer dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .root_addr(root_addr), .ray_dir_neg(ray_dir_neg), .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready), .fetch_addr(fetch_addr), .resp_valid(resp_valid),
        .resp_word(resp_word), .resp_hit(resp_hit), .leaf_valid(leaf_valid),
        .leaf_ready(leaf_ready), .leaf_prim_index(leaf_prim_index),
        .leaf_prim_count(leaf_prim_count), .busy(busy), .done(done), .overflow(overflow)
    );
    int checks = 0, errors = 0;
    logic [127:0] mem_w [int unsigned];
    bit mem_h [int unsigned];
    logic [AW-1:0] exp_f[$], got_f[$];
    logic [31:0] exp_l[$], got_l[$];
    bit exp_ovf;
    int cyc = 0, done_cnt = 0, resp_cyc = 0, done_cyc = 0, pend = 0, pend_dly = 0;
    int fr_delay = -1, fv_cnt = 0, leaf_delay = -1, lv_cnt = 0;
    bit spur = 0;
    logic [AW-1:0] pend_addr, fsave;
    logic [31:0] lsave;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] rw(input logic [AW-1:0] a);
        return mem_w.exists(int'(a)) ? mem_w[int'(a)] : 128'h0;
    endfunction
    function automatic bit rh(input logic [AW-1:0] a);
        return mem_h.exists(int'(a)) ? mem_h[int'(a)] : 1'b0;
    endfunction
    function automatic logic [63:0] gf(input int i);
        return i < got_f.size() ? 64'(got_f[i]) : 'x;
    endfunction
    function automatic logic [63:0] gl(input int i);
        return i < got_l.size() ? 64'(got_l[i]) : 'x;
    endfunction
    function automatic logic [127:0] leaf_w(input logic [18:0] idx, input logic [11:0] cnt);
        return {$urandom, $urandom, $urandom, 1'b1, idx, cnt};
    endfunction
    function automatic logic [127:0] int_w(input logic [1:0] ax, input logic [13:0] o0, input logic [14:0] o1);
        return {$urandom, $urandom, $urandom, 1'b0, ax, o0, o1};
    endfunction

    // Depth-first walk: visit near child first, defer far child (dropped when stack holds SD).
    task automatic model(input logic [AW-1:0] root, input logic [2:0] dir);
        logic [AW-1:0] stk[$];
        logic [AW-1:0] cur, c0, c1;
        logic [127:0] w;
        int ax;
        cur = root;
        exp_f.delete();
        exp_l.delete();
        exp_ovf = 0;
        while (exp_f.size() < 5000) begin
            exp_f.push_back(cur);
            w = rw(cur);
            if (rh(cur) && !w[31]) begin
                ax = (w[30:29] == 2'd3) ? 0 : int'(w[30:29]);
                c0 = cur + AW'(w[28:15]);
                c1 = cur + AW'(w[14:0]);
                if (stk.size() < SD) stk.push_back(dir[ax] ? c0 : c1);
                else exp_ovf = 1;
                cur = dir[ax] ? c1 : c0;
                continue;
            end
            if (rh(cur) && w[11:0] != 0) exp_l.push_back({1'b0, w[30:12], w[11:0]});
            if (stk.size() == 0) break;
            cur = stk.pop_back();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        resp_valid = 0;
        if (pend != 0) begin
            if (pend_dly == 0) begin
                resp_valid = 1;
                resp_word = rw(pend_addr);
                resp_hit = rh(pend_addr);
                resp_cyc = cyc;
                pend = 0;
            end else pend_dly--;
        end
        if (fetch_valid) begin
            if (fv_cnt > 0) chk("fetch_addr_stable", 64'(fetch_addr), 64'(fsave));
            fsave = fetch_addr;
            fetch_ready = (fr_delay < 0) ? 1'($urandom_range(0, 1)) : (fv_cnt >= fr_delay);
            fv_cnt++;
            if (!fetch_ready && spur && !resp_valid) begin
                resp_valid = 1;
                resp_word = {96'h0, 32'h8000_1003};
                resp_hit = 1;
            end
            if (fetch_ready) begin
                got_f.push_back(fetch_addr);
                pend = 1;
                pend_dly = $urandom_range(0, 2);
                pend_addr = fetch_addr;
                fv_cnt = 0;
            end
        end else fetch_ready = 1'($urandom_range(0, 1));
        if (leaf_valid) begin
            if (lv_cnt > 0) chk("leaf_stable", 64'({leaf_prim_index, leaf_prim_count}), 64'(lsave));
            lsave = {leaf_prim_index, leaf_prim_count};
            leaf_ready = (leaf_delay < 0) ? 1'($urandom_range(0, 1)) : (lv_cnt >= leaf_delay);
            lv_cnt++;
            if (leaf_ready) begin
                got_l.push_back({leaf_prim_index, leaf_prim_count});
                lv_cnt = 0;
            end
        end else leaf_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_ray(input logic [AW-1:0] root, input logic [2:0] dir);
        int n;
        model(root, dir);
        n = 0;
        while (!start_ready && n < 50) begin
            tick();
            n++;
        end
        got_f.delete();
        got_l.delete();
        pend = 0;
        fv_cnt = 0;
        lv_cnt = 0;
        start_valid = 1;
        root_addr = root;
        ray_dir_neg = dir;
        tick();
        start_valid = 0;
        done_cnt = 0;
        chk("start_fetch_latency", 64'(fetch_valid), 64'(1));
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_ovf_clear", 64'(overflow), 64'(0));
    endtask

    task automatic finish_ray(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt > 0), 64'(1));
        tick();
        chk({tag, "_done_pulse"}, 64'(done_cnt), 64'(1));
        chk({tag, "_busy_end"}, 64'(busy), 64'(0));
        chk({tag, "_start_ready_end"}, 64'(start_ready), 64'(1));
        chk({tag, "_fetch_count"}, 64'(got_f.size()), 64'(exp_f.size()));
        for (int i = 0; i < exp_f.size(); i++) chk({tag, "_fetch_addr"}, gf(i), 64'(exp_f[i]));
        chk({tag, "_leaf_count"}, 64'(got_l.size()), 64'(exp_l.size()));
        for (int i = 0; i < exp_l.size(); i++) chk({tag, "_leaf"}, gl(i), 64'(exp_l[i]));
        chk({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
    endtask

    task automatic run_ray(input string tag, input logic [AW-1:0] root, input logic [2:0] dir);
        start_ray(root, dir);
        finish_ray(tag);
    endtask

    task automatic gen_tree(input logic [AW-1:0] root);
        logic [AW-1:0] qa[$];
        int qd[$];
        logic [AW-1:0] a;
        logic [13:0] o0;
        logic [14:0] o1;
        int d;
        mem_w.delete();
        mem_h.delete();
        qa.push_back(root);
        qd.push_back(0);
        while (qa.size() > 0) begin
            a = qa.pop_front();
            d = qd.pop_front();
            if (d >= 5 || $urandom_range(0, 99) < 30)
                mem_w[int'(a)] = leaf_w(19'($urandom), 12'($urandom_range(0, 4)));
            else begin
                o0 = 14'($urandom_range(1, 60));
                o1 = 15'($urandom_range(1, 60));
                mem_w[int'(a)] = int_w(2'($urandom), o0, o1);
                qa.push_back(a + AW'(o0));
                qd.push_back(d + 1);
                qa.push_back(a + AW'(o1));
                qd.push_back(d + 1);
            end
            mem_h[int'(a)] = $urandom_range(0, 99) < 85;
        end
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_fetch_valid", 64'(fetch_valid), 64'(0));
        chk("rst_leaf_valid", 64'(leaf_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_fetch_addr", 64'(fetch_addr), 64'(0));
        chk("rst_leaf_fields", 64'({leaf_prim_index, leaf_prim_count}), 64'(0));
        chk("rst_start_ready", 64'(start_ready), 64'(1));
        rst = 0;
        tick();
        // root is a hit leaf, consumer stalls 4 cycles
        mem_w[32'h80] = leaf_w(19'h5, 12'd3);
        mem_h[32'h80] = 1;
        leaf_delay = 4;
        run_ray("root_leaf", 24'h80, 3'b000);
        leaf_delay = -1;
        chk("root_leaf_value", gl(0), 64'({20'h00005, 12'd3}));
        // interior root, near child is child1 because y is negative
        mem_w.delete();
        mem_h.delete();
        mem_w[32'h100] = int_w(2'd1, 14'd2, 15'd5);
        mem_h[32'h100] = 1;
        mem_w[32'h105] = leaf_w(19'h11, 12'd2);
        mem_h[32'h105] = 1;
        mem_w[32'h102] = leaf_w(19'h22, 12'd1);
        mem_h[32'h102] = 1;
        run_ray("interior", 24'h100, 3'b010);
        chk("interior_order1", gf(1), 64'(24'h105));
        chk("interior_order2", gf(2), 64'(24'h102));
        // fetch_ready stalls with a spurious response during FETCH
        fr_delay = 5;
        spur = 1;
        run_ray("fetch_stall", 24'h100, 3'b010);
        fr_delay = -1;
        spur = 0;
        // root miss
        mem_w[32'h300] = leaf_w(19'h1, 12'd1);
        mem_h[32'h300] = 0;
        run_ray("root_miss", 24'h300, 3'b000);
        chk("miss_done_latency", 64'(done_cyc - resp_cyc), 64'(2));
        chk("miss_no_leaf", 64'(got_l.size()), 64'(0));
        // 10-deep left chain overflows the 8-entry stack
        mem_w.delete();
        mem_h.delete();
        for (int i = 0; i < 10; i++) begin
            mem_w[32'h200 + i] = int_w(2'd0, 14'd1, 15'h1000);
            mem_h[32'h200 + i] = 1;
        end
        mem_w[32'h20A] = leaf_w(19'h33, 12'd2);
        mem_h[32'h20A] = 1;
        run_ray("chain", 24'h200, 3'b000);
        chk("chain_overflow", 64'(overflow), 64'(1));
        mem_w[32'h80] = leaf_w(19'h5, 12'd3);
        mem_h[32'h80] = 1;
        run_ray("after_chain", 24'h80, 3'b000);
        // reset while a leaf is being offered
        mem_w[32'h40] = leaf_w(19'h7, 12'd1);
        mem_h[32'h40] = 1;
        leaf_delay = 1000;
        start_ray(24'h40, 3'b000);
        n = 0;
        while (!leaf_valid && n < 50) begin
            tick();
            n++;
        end
        chk("emit_reached", 64'(leaf_valid), 64'(1));
        rst = 1;
        #1;
        chk("rst_emit_leaf_valid", 64'(leaf_valid), 64'(0));
        chk("rst_emit_busy", 64'(busy), 64'(0));
        chk("rst_emit_start_ready", 64'(start_ready), 64'(1));
        tick();
        rst = 0;
        pend = 0;
        lv_cnt = 0;
        fv_cnt = 0;
        leaf_delay = -1;
        run_ray("after_rst", 24'h100, 3'b010);
        // random trees
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] r;
            r = AW'($urandom_range(0, 16'hFFFF));
            gen_tree(r);
            run_ray("random", r, 3'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
